// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the handshaked ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OpZero, OpAdd, OpAbsDiff, OpPassA, OpXor, OpOr, OpAnd, OpInc,
        OpSub, OpShl, OpShr, OpMul, OpRsv12, OpRsv13, OpRsv14, OpRsv15
    } alu_op_t;

    typedef enum logic {StIdle, StMul} alu_state_t;

    localparam alu_op_t ALU_OP_MUL = OpMul;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle after start_i.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic               active_q, active_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end else if (active_q && (cnt_q != '0)) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end else if (active_q) begin
            // Result is taken by the parent on this edge.
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign done_o = active_q && (cnt_q == '0);
    assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result and flags.
// Define ALU_MUL_EN to build opcode 11 as an iterative multiplier; otherwise it is reserved.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   sum_w, diff_w, inc_w;
    logic [WIDTH-1:0] res_c;
    logic             carry_c, err_c;
    logic             idle, accept, is_mul;

    always_comb begin
        sum_w   = {1'b0, A} + {1'b0, B};
        diff_w  = {1'b0, A} - {1'b0, B};
        inc_w   = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        case (alu_op_t'(s))
            OpZero:    res_c = '0;
            OpAdd:     begin res_c = sum_w[WIDTH-1:0]; carry_c = sum_w[WIDTH]; end
            OpAbsDiff: begin
                carry_c = diff_w[WIDTH];
                res_c   = diff_w[WIDTH] ? (B - A) : diff_w[WIDTH-1:0];
            end
            OpPassA:   res_c = A;
            OpXor:     res_c = A ^ B;
            OpOr:      res_c = A | B;
            OpAnd:     res_c = A & B;
            OpInc:     begin res_c = inc_w[WIDTH-1:0]; carry_c = inc_w[WIDTH]; end
            OpSub:     begin res_c = diff_w[WIDTH-1:0]; carry_c = diff_w[WIDTH]; end
            OpShl:     res_c = A << B[SHW-1:0];
            OpShr:     res_c = A >> B[SHW-1:0];
            default:   err_c = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    alu_state_t         state_q, state_d;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .a_i     (A),
        .b_i     (B),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    assign idle   = (state_q == StIdle);
    assign is_mul = (s == ALU_OP_MUL);
`else
    assign idle   = 1'b1;
    assign is_mul = 1'b0;
`endif

    assign in_ready = idle && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        err_d   = err_q;
        valid_d = valid_q && !out_ready;
        if (accept && !is_mul) begin
            q_d     = res_c;
            carry_d = carry_c;
            err_d   = err_c;
            valid_d = 1'b1;
        end
`ifdef ALU_MUL_EN
        state_d   = state_q;
        mul_start = accept && is_mul;
        if (mul_start) begin
            state_d = StMul;
        end
        // Output slot is already free here: entering StMul required it.
        if ((state_q == StMul) && mul_done) begin
            q_d     = mul_prod[WIDTH-1:0];
            carry_d = |mul_prod[2*WIDTH-1:WIDTH];
            err_d   = 1'b0;
            valid_d = 1'b1;
            state_d = StIdle;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q <= StIdle;
`endif
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            valid_q <= valid_d;
`ifdef ALU_MUL_EN
            state_q <= state_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign Q         = q_q;
    assign zero      = (q_q == '0);
    assign carry     = carry_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, stall/multiply sequences, random scoreboard run.
module tb_alu_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   s;
    logic [W-1:0] A, B, Q;
    logic         zero, carry, err;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         c;
        logic         e;
        int           due;
    } exp_t;

    typedef struct {
        logic [3:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic         c;
        logic         e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    exp_t cur;
    bit   seen;
    int   cyc;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit mul_op(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == 4'd11;
`else
        return (op == 4'd11) && 1'b0;
`endif
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        r;
        logic [W:0]  t;
        logic [31:0] p;
        r.q = '0; r.c = 1'b0; r.e = 1'b0; r.due = 0;
        case (op)
            4'd0:  r.q = '0;
            4'd1:  begin t = {1'b0, a} + {1'b0, b}; r.q = t[W-1:0]; r.c = t[W]; end
            4'd2:  begin r.c = (a < b); r.q = r.c ? (b - a) : (a - b); end
            4'd3:  r.q = a;
            4'd4:  r.q = a ^ b;
            4'd5:  r.q = a | b;
            4'd6:  r.q = a & b;
            4'd7:  begin t = {1'b0, a} + 17'd1; r.q = t[W-1:0]; r.c = t[W]; end
            4'd8:  begin r.q = a - b; r.c = (a < b); end
            4'd9:  r.q = a << b[3:0];
            4'd10: r.q = a >> b[3:0];
`ifdef ALU_MUL_EN
            4'd11: begin p = {16'd0, a} * {16'd0, b}; r.q = p[15:0]; r.c = |p[31:16]; end
`endif
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    // One clock: sample handshakes before the edge, then check the first appearance of a result.
    task automatic step(output bit acc);
        exp_t h;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                h = sb.pop_front();
                chk("q", {16'd0, Q}, {16'd0, h.q});
                chk("zero", {31'd0, zero}, {31'd0, h.q == '0});
                chk("carry", {31'd0, carry}, {31'd0, h.c});
                chk("err", {31'd0, err}, {31'd0, h.e});
                seen = 1'b0;
            end
        end
        if (acc) begin
            e     = cur;
            e.due = cyc + 1 + (mul_op(s) ? int'(W) + 1 : 0);
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (out_valid && !seen && sb.size() != 0) begin
            chk("latency", cyc, sb[0].due);
            seen = 1'b1;
        end
    endtask

    initial begin
        bit acc;
        int tries;
        n_tests = 0; n_fail = 0; cyc = 0; seen = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; s = '0; A = '0; B = '0;

        tbl.push_back('{4'd1,  16'd10,     16'd11,     16'd21,     1'b0, 1'b0});
        tbl.push_back('{4'd1,  16'hFFFF,   16'd1,      16'd0,      1'b1, 1'b0});
        tbl.push_back('{4'd8,  16'd10,     16'd11,     16'hFFFF,   1'b1, 1'b0});
        tbl.push_back('{4'd2,  16'd10,     16'd11,     16'd1,      1'b1, 1'b0});
        tbl.push_back('{4'd4,  16'd10,     16'd11,     16'd1,      1'b0, 1'b0});
        tbl.push_back('{4'd5,  16'd10,     16'd11,     16'd11,     1'b0, 1'b0});
        tbl.push_back('{4'd6,  16'd10,     16'd11,     16'd10,     1'b0, 1'b0});
        tbl.push_back('{4'd7,  16'd10,     16'd11,     16'd11,     1'b0, 1'b0});
        tbl.push_back('{4'd7,  16'hFFFF,   16'd0,      16'd0,      1'b1, 1'b0});
        tbl.push_back('{4'd2,  16'd30,     16'd7,      16'd23,     1'b0, 1'b0});
        tbl.push_back('{4'd8,  16'd0,      16'd1,      16'hFFFF,   1'b1, 1'b0});
        tbl.push_back('{4'd3,  16'h1234,   16'h5555,   16'h1234,   1'b0, 1'b0});
        tbl.push_back('{4'd0,  16'h1234,   16'h5555,   16'd0,      1'b0, 1'b0});
        tbl.push_back('{4'd9,  16'd1,      16'h0013,   16'd8,      1'b0, 1'b0});
        tbl.push_back('{4'd10, 16'h8000,   16'h000F,   16'd1,      1'b0, 1'b0});
        tbl.push_back('{4'd12, 16'd5,      16'd6,      16'd0,      1'b0, 1'b1});
        tbl.push_back('{4'd14, 16'd5,      16'd6,      16'd0,      1'b0, 1'b1});
        tbl.push_back('{4'd15, 16'hFFFF,   16'hFFFF,   16'd0,      1'b0, 1'b1});
`ifndef ALU_MUL_EN
        tbl.push_back('{4'd11, 16'd300,    16'd300,    16'd0,      1'b0, 1'b1});
`endif

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_q", {16'd0, Q}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back table vectors with the consumer always ready.
        foreach (tbl[i]) begin
            in_valid = 1'b1; s = tbl[i].s; A = tbl[i].a; B = tbl[i].b;
            cur = '{tbl[i].q, tbl[i].c, tbl[i].e, 0};
            step(acc);
            chk("tbl_accept", {31'd0, acc}, 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) step(acc);

        // Stalled consumer: result held, new op waits, then accepted as the old one drains.
        in_valid = 1'b1; out_ready = 1'b0; s = 4'd9; A = 16'd1; B = 16'h0013;
        cur = '{16'd8, 1'b0, 1'b0, 0};
        step(acc);
        chk("stall_first_acc", {31'd0, acc}, 32'd1);
        s = 4'd1; A = 16'd2; B = 16'd3;
        cur = '{16'd5, 1'b0, 1'b0, 0};
        for (int i = 0; i < 5; i++) begin
            step(acc);
            chk("stall_ignored", {31'd0, acc}, 32'd0);
            chk("stall_q", {16'd0, Q}, 32'd8);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        step(acc);
        chk("stall_release_acc", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        repeat (2) step(acc);

`ifdef ALU_MUL_EN
        // Multiply: W+1 cycles with in_ready low, then a registered product.
        in_valid = 1'b1; s = 4'd11; A = 16'd300; B = 16'd300;
        cur = '{16'h5F90, 1'b1, 1'b0, 0};
        step(acc);
        chk("mul_acc", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < int'(W) + 1; i++) begin
            chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
            chk("mul_no_valid", {31'd0, out_valid}, 32'd0);
            step(acc);
        end
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        step(acc);

        // Reset during a multiply aborts it with no output.
        in_valid = 1'b1; s = 4'd11; A = 16'd7; B = 16'd9;
        cur = '{16'd63, 1'b0, 1'b0, 0};
        step(acc);
        chk("abort_acc", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        repeat (8) step(acc);
        rst_n = 1'b0;
        sb.delete();
        seen = 1'b0;
        #1;
        chk("abort_q", {16'd0, Q}, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        chk("abort_carry", {31'd0, carry}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(acc);
            chk("abort_quiet", {31'd0, out_valid}, 32'd0);
        end
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
`endif

        // Random operations with a randomly stalling consumer.
        for (int n = 0; n < 40; n++) begin
            in_valid = 1'b1;
            s = 4'($urandom_range(0, 15));
            A = 16'($urandom);
            B = 16'($urandom);
            cur = model(s, A, B);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 60) begin
                out_ready = ($urandom_range(0, 3) != 0);
                step(acc);
                tries++;
            end
            if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) step(acc);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
